// File: rtl/prog_div_pkg.sv
// rtl/prog_div_pkg.sv - shared constants and helpers for the programmable clock divider
package prog_div_pkg;

   localparam int unsigned DIV_WIDTH_DEF = 8;
   localparam int unsigned DIV_DEFAULT   = 10;

   // Callers size-cast the 32-bit result down to WIDTH+1 bits.
   function automatic logic [31:0] half_ceil(input logic [31:0] n);
      return (n + 32'd1) >> 1;
   endfunction

   // Divisors 0 and 1 both mean "tick every enabled cycle".
   function automatic logic [31:0] clamp_div(input logic [31:0] n);
      return (n == 32'd0) ? 32'd1 : n;
   endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// rtl/prog_clk_divider_if.sv - divisor load handshake and divider outputs
interface prog_clk_divider_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic [WIDTH-1:0] div_in;
   logic             div_valid;
   logic             div_ready;
   logic             tick;
   logic             clk_out;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] div_cur;

   modport master (
      output en, div_in, div_valid,
      input  div_ready, tick, clk_out, cnt, div_cur
   );

   modport slave (
      input  en, div_in, div_valid,
      output div_ready, tick, clk_out, cnt, div_cur
   );
endinterface

// File: rtl/div_phase_counter.sv
// rtl/div_phase_counter.sv - phase counter with enable, synchronous load and terminal compare
module div_phase_counter #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic [WIDTH-1:0] div_cur_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic [WIDTH-1:0] cnt_nxt_o,
   output logic             tc_o
);
   logic [WIDTH-1:0] cnt_q, cnt_d;

   // div_cur_i is never 0, so the subtraction cannot underflow.
   assign tc_o = (cnt_q == div_cur_i - WIDTH'(1));

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= RST_VAL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/prog_clk_divider.sv
// rtl/prog_clk_divider.sv - runtime-programmable clock-enable divider with glitch-free divisor update
module prog_clk_divider
   import prog_div_pkg::*;
#(
   parameter int unsigned WIDTH       = DIV_WIDTH_DEF,
   parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   prog_clk_divider_if.slave  bus
);
   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(DEFAULT_DIV - 1);

   logic [WIDTH-1:0] div_cur_q, div_cur_d;
   logic [WIDTH-1:0] pend_val_q, pend_val_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             clk_out_q, clk_out_d;

   logic             tc, wrap, accept, cnt_load;
   logic [WIDTH-1:0] cnt, cnt_nxt, acc_val, load_val;
   logic [WIDTH:0]   half_cur;

   assign accept   = bus.div_valid && !pend_q;
   assign acc_val  = WIDTH'(clamp_div(32'(bus.div_in)));
   assign wrap     = bus.en && tc;
   assign half_cur = (WIDTH+1)'(half_ceil(32'(div_cur_q)));

   div_phase_counter #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_CNT)
   ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (bus.en),
      .load_i     (cnt_load),
      .load_val_i (load_val),
      .div_cur_i  (div_cur_q),
      .cnt_o      (cnt),
      .cnt_nxt_o  (cnt_nxt),
      .tc_o       (tc)
   );

   always_comb begin
      div_cur_d  = div_cur_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
      tick_d     = 1'b0;
      clk_out_d  = clk_out_q;
      cnt_load   = 1'b0;
      load_val   = '0;
      if (bus.en) begin
         tick_d    = wrap;
         clk_out_d = ({1'b0, cnt_nxt} < half_cur);
         // A new divisor only takes effect where the counter restarts at 0.
         if (wrap && pend_q) begin
            div_cur_d = pend_val_q;
            pend_d    = 1'b0;
         end else if (wrap && accept) begin
            div_cur_d = acc_val;
         end else if (accept) begin
            pend_d     = 1'b1;
            pend_val_d = acc_val;
         end
      end else if (pend_q) begin
         // Park at the last phase so the first enabled edge starts a clean period.
         div_cur_d = pend_val_q;
         pend_d    = 1'b0;
         cnt_load  = 1'b1;
         load_val  = pend_val_q - WIDTH'(1);
         clk_out_d = 1'b0;
      end else if (accept) begin
         pend_d     = 1'b1;
         pend_val_d = acc_val;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cur_q  <= RST_DIV;
         pend_val_q <= '0;
         pend_q     <= 1'b0;
         tick_q     <= 1'b0;
         clk_out_q  <= 1'b0;
      end else begin
         div_cur_q  <= div_cur_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
         tick_q     <= tick_d;
         clk_out_q  <= clk_out_d;
      end
   end

   assign bus.div_ready = !pend_q;
   assign bus.tick      = tick_q;
   assign bus.clk_out   = clk_out_q;
   assign bus.cnt       = cnt;
   assign bus.div_cur   = div_cur_q;

endmodule

// File: doc/prog_clk_divider.md
Name: prog_clk_divider

Overview:
Runtime-programmable clock-enable divider, successor to the fixed-N divider.
- Divisor is loaded through a valid/ready handshake and applied glitch-free at a period boundary.
- Outputs: a one-cycle tick every N enabled cycles, plus a registered near-50% duty square wave.
- Sits between the system clock and slow peripherals (UART baud, LED scan, sampling strobes); consumers use tick as a clock enable.

Parameters:
- WIDTH, 8, divisor/counter width; max divisor 2^WIDTH-1.
- DEFAULT_DIV, 10, divisor after reset; must satisfy 2 <= DEFAULT_DIV <= 2^WIDTH-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable; 0 freezes the divider.
- div_in  in  WIDTH  requested divisor N.
- div_valid  in  1  div_in is valid.
- div_ready  out  1  a new divisor can be accepted.
- tick  out  1  registered one-cycle pulse, once per period.
- clk_out  out  1  registered square wave, period N.
- cnt  out  WIDTH  current phase, 0..N_cur-1.
- div_cur  out  WIDTH  divisor currently in effect.

Behaviour:
- Reset (async, rst_n=0):
  - cnt = DEFAULT_DIV-1, div_cur = DEFAULT_DIV.
  - tick = 0, clk_out = 0.
  - Pending register empty, div_ready = 1.
- Effective divisor: divisor values 0 and 1 are both stored as 1 (clamp on accept).
- Square-wave high count: H = ceil(N_cur/2), computed in WIDTH+1 bits.
- Wrap = en && cnt == div_cur-1.
- Each edge with en=1:
  - cnt <= wrap ? 0 : cnt+1.
  - tick <= wrap.
  - clk_out <= (next cnt < H).
  - Result: the first enabled edge after reset wraps, so tick=1 and clk_out=1 in that following cycle.
- en=0: cnt and clk_out hold, tick <= 0. Re-enabling resumes from the held phase.
- Duty: clk_out is high for ceil(N/2) cycles and low for floor(N/2). N=1 gives clk_out constant 1 and tick constant 1 while enabled.
- Handshake:
  - Accept when div_valid && div_ready; the clamped value goes into the pending register.
  - div_ready = !pending. Only one update can be outstanding.
  - div_in is sampled only on the accept edge.
- Apply, enabled case: at a wrap edge with pending set, div_cur <= pending, cnt <= 0, clk_out <= 1, pending cleared, div_ready = 1 in the next cycle.
- Apply, accept coincident with wrap: the new value is applied at that same edge (bypass); the pending register is not used and div_ready stays 1.
- Apply, disabled case: with en=0 and pending set, apply on the next edge: div_cur <= pending, cnt <= pending-1, clk_out <= 0, tick = 0. The next enabled edge starts a clean period.
- The current period always completes with the old divisor. No runt high or low phase while enabled.
- Mid-operation reset clears the pending update and restores DEFAULT_DIV immediately (async). Outputs take their reset values with no clock.
- No X on outputs after reset. All outputs are registers, or combinational from registers only (div_ready).

Decomposition:
- Shared package prog_div_pkg holds:
  - default constants DIV_WIDTH_DEF=8 and DIV_DEFAULT=10;
  - a function half_ceil(n) returning (n+1)>>1 at WIDTH+1 bits;
  - a function clamp_div(n) returning max(n,1).
- One sub-module, div_phase_counter: the WIDTH-bit phase counter with enable, synchronous load (value, load), and a terminal-count compare against div_cur-1.
- The top level holds the handshake, the pending register and the output registers.

Test Plan:
- Reset, en=1, default N=10 → tick every 10 cycles, first tick 1 cycle after en; clk_out high 5 cycles, low 5.
- Load div_in=3 mid-period (cnt=4) → current 10-cycle period completes; afterwards tick every 3 cycles, clk_out 2 high / 1 low; div_ready low until the wrap.
- Load div_in=0, then div_in=1 → both stored as 1; tick and clk_out held high continuously while en=1; div_cur reads 1.
- en=0 for 7 cycles mid-period → cnt, clk_out frozen and tick=0; resume gives the remaining cycles of the period before the next tick; load div_in=4 while disabled → cnt=3, clk_out=0, first re-enabled edge ticks.
- Accept div_in=6 exactly on a wrap cycle, then hold div_valid with div_in=9 → 6 applied at that edge; 9 accepted on the next cycle and applied at the following wrap (6 cycles later).
- Assert rst_n=0 asynchronously between edges with an update pending → outputs drop to reset values immediately; after release the divider runs at N=10 and the pending value is lost.
